seg7_scan_driver: RTL

//  Time-multiplexed driver for a NUM_DIGITS common-anode 7-segment display; next generation of our single-digit hex decoder.

---
 rtl/seg7_scan_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver: one digit per dwell, anti-ghost
// blanking at the start of each dwell, leading-zero suppression and per-digit blink.

module seg7_scan_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  input  logic       blink,
  input  logic       phase,
  input  logic       supp,
  output logic [7:0] seg,
  output logic       dark
);
  logic [6:0] hex;

  // segments g..a, active low
  always_comb begin
    hex = 7'h7F;
    unique case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
    endcase
  end

  assign seg  = {~dp, hex};
  assign dark = blank | supp | (blink & phase);
endmodule

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_CYCLES = 12500000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    lz_suppress,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   digit_en
);
  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
    logic [NUM_DIGITS-1:0]      blink;
    logic                       lz;
  } disp_t;

  localparam disp_t DISP_RST = '{digits: '0, dp: '0, blank: '1, blink: '0, lz: 1'b0};

  disp_t                 cap, pend, act;
  logic                  pend_valid;
  logic [DW-1:0]         dwell_cnt;
  logic [IW-1:0]         idx;
  logic                  boundary;
  logic [BW-1:0]         blink_cnt;
  logic                  phase;
  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0][7:0] lane_seg;
  logic [NUM_DIGITS-1:0] lane_dark;

  assign cap      = {digits_in, dp_in, blank_in, blink_in, lz_suppress};
  assign boundary = (dwell_cnt == DWELL_LAST);

  // A load on the boundary edge lands in pending and waits a full dwell.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt  <= '0;
      idx        <= '0;
      pend       <= DISP_RST;
      act        <= DISP_RST;
      pend_valid <= 1'b0;
    end else begin
      if (boundary) begin
        dwell_cnt <= '0;
        idx       <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        if (pend_valid) act <= pend;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end
      if (load) begin
        pend       <= cap;
        pend_valid <= 1'b1;
      end else if (boundary) begin
        pend_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk down from the top digit; a blanked digit does not stop the zero run.
  always_comb begin
    logic above_dark;
    above_dark = 1'b1;
    supp       = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      supp[i]    = act.lz && (act.digits[i] == 4'h0) && !act.dp[i] && above_dark;
      above_dark = above_dark && (supp[i] || act.blank[i]);
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    seg7_scan_lane u_lane (
      .nib   (act.digits[g]),
      .dp    (act.dp[g]),
      .blank (act.blank[g]),
      .blink (act.blink[g]),
      .phase (phase),
      .supp  (supp[g]),
      .seg   (lane_seg[g]),
      .dark  (lane_dark[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      leds     <= 8'hFF;
      digit_en <= '1;
    end else if ((dwell_cnt < BLANK_END) || lane_dark[idx]) begin
      leds     <= 8'hFF;
      digit_en <= '1;
    end else begin
      leds     <= lane_seg[idx];
      digit_en <= ~(NUM_DIGITS'(1) << idx);
    end
  end
endmodule
